fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the instruction memory for the core. Owns the fetch PC, drives the word-addressed instruction memory read port, buffers fetched words with their PCs in a 2-entry FIFO, and delivers them to decode over a valid/ready handshake. Supports redirects from branch/jump resolution and flags misaligned or out-of-range fetches as a sticky fault.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_ctrl_if.sv | 22 ++
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_ctrl.sv | 57 +++++
 tb/tb_fetch_ctrl.sv | 130 +++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, reset PC, memory/FIFO sizes, FSM states, fetch entry and range check
package fetch_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int MEM_WORDS = 2049;
  localparam int FIFO_DEPTH = 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic {RUN, HALT} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  function automatic logic in_range(input logic [XLEN-1:0] a);
    return a[1:0] == 2'b00 && a[XLEN-1:2] < (XLEN-2)'(MEM_WORDS);
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: imem read port, redirect input, decode valid/ready output and fault status; master = fetch_ctrl, slave = core/memory side
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic fault;
  logic [XLEN-1:0] fault_pc;
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    input imem_instr, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry {pc,instr} buffer; ports push/pop/flush/din in, head/count out; flush beats push
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && count != '0;
  assign head = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= inc(wp);
      end
      if (do_pop) rp <= inc(rp);
      count <= count + NW'(push) - NW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns fetch PC, drives imem read, buffers words in fetch_fifo, hands them to decode, raises sticky fault on bad fetch
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fetch_ctrl_if.master bus
);
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, fpc_q, fpc_n;
  logic fault_q, fault_n;
  logic [CW-1:0] count;
  fetch_entry_t head, ent;
  logic deq, cap, pc_ok, tgt_ok, trap;
  assign deq = bus.out_valid & bus.out_ready;
  assign pc_ok = in_range(pc);
  assign tgt_ok = in_range(bus.redirect_pc);
  // a pop frees the slot this cycle, so a full buffer still accepts a capture
  assign cap = state == RUN && !bus.redirect_valid && pc_ok && (count < CW'(FIFO_DEPTH) || deq);
  assign trap = state == RUN && !bus.redirect_valid && !pc_ok;
  assign ent = '{pc: pc, instr: bus.imem_instr};
  always_comb begin
    state_n = bus.redirect_valid ? (tgt_ok ? RUN : HALT) : trap ? HALT : state;
    pc_n = bus.redirect_valid ? bus.redirect_pc : cap ? pc + 32'd4 : pc;
    fault_n = bus.redirect_valid ? !tgt_ok : trap ? 1'b1 : fault_q;
    fpc_n = bus.redirect_valid && !tgt_ok ? bus.redirect_pc : trap ? pc : fpc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
      fault_q <= 1'b0;
      fpc_q <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fault_q <= fault_n;
      fpc_q <= fpc_n;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(cap),
    .pop(deq),
    .flush(bus.redirect_valid),
    .din(ent),
    .head(head),
    .count(count)
  );
  assign bus.imem_addr = pc;
  assign bus.out_valid = count != '0;
  assign bus.out_instr = head.instr;
  assign bus.out_pc = head.pc;
  assign bus.fault = fault_q;
  assign bus.fault_pc = fpc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: per-cycle vector table plus delivery scoreboard for fetch_ctrl
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;
  typedef struct {
    logic rv;
    logic [31:0] rpc;
    logic rdy;
    logic ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic ef;
    logic [31:0] efpc;
  } vec_t;
  logic clk, rst_n;
  int nvec, nerr;
  vec_t tbl[$];
  fetch_entry_t sb[$];
  fetch_ctrl_if bus();
  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[31:2])
      30'd0: return 32'h0000_0013;
      30'd1: return 32'h0010_0093;
      30'd2: return 32'h0020_0113;
      30'd3: return 32'h0030_0193;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction
  assign bus.imem_instr = mem_word(bus.imem_addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy, input logic ev,
                              input logic [31:0] epc, eaddr, input logic ef, input logic [31:0] efpc);
    return '{rv, rpc, rdy, ev, epc, eaddr, ef, efpc};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input vec_t t);
    fetch_entry_t g;
    bus.redirect_valid = t.rv;
    bus.redirect_pc = t.rpc;
    bus.out_ready = t.rdy;
    if (t.ev && t.rdy) sb.push_back({t.epc, mem_word(t.epc)});
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(t.ev));
    chk("imem_addr", bus.imem_addr, t.eaddr);
    chk("fault", 32'(bus.fault), 32'(t.ef));
    if (t.ef) chk("fault_pc", bus.fault_pc, t.efpc);
    if (t.ev) begin
      chk("out_pc", bus.out_pc, t.epc);
      chk("out_instr", bus.out_instr, mem_word(t.epc));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_pop", bus.out_pc, 32'hFFFF_FFFF);
      else begin
        g = sb.pop_front();
        chk("sb_pc", bus.out_pc, g.pc);
        chk("sb_instr", bus.out_instr, g.instr);
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0, 32'h4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h4, 32'h8, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h8, 32'hC, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hC, 32'h10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h10, 32'h14, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 32'h10, 32'h18, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h10, 32'h18, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h14, 32'h1C, 0, 0));
    tbl.push_back(mk(1, 32'h40, 1, 1, 32'h18, 32'h20, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h40, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h40, 32'h44, 0, 0));
    tbl.push_back(mk(1, 32'h42, 1, 1, 32'h44, 32'h48, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h42, 1, 32'h42));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h42, 1, 32'h42));
    tbl.push_back(mk(1, 32'h100, 1, 0, 0, 32'h42, 1, 32'h42));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h100, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h100, 32'h104, 0, 0));
    tbl.push_back(mk(1, 32'h1FFC, 1, 1, 32'h104, 32'h108, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h1FFC, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h1FFC, 32'h2000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h2000, 32'h2004, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h2004, 1, 32'h2004));
    tbl.push_back(mk(1, 32'h0, 1, 0, 0, 32'h2004, 1, 32'h2004));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 32'h4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 32'h8, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_fault_pc", bus.fault_pc, 0);
    foreach (tbl[i]) step(tbl[i]);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_imem_addr", bus.imem_addr, RESET_PC);
    chk("midrst_fault", 32'(bus.fault), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(0, 0, 1, 0, 0, 32'h0, 0, 0));
    step(mk(0, 0, 1, 1, 32'h0, 32'h4, 0, 0));
    step(mk(1, 32'h2004, 1, 1, 32'h4, 32'h8, 0, 0));
    step(mk(0, 0, 1, 0, 0, 32'h2004, 1, 32'h2004));
    step(mk(0, 0, 1, 0, 0, 32'h2004, 1, 32'h2004));
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
